// File: rtl/ddr_responder.sv
`timescale 1ns/1ps
// ddr_responder: behavioural DDR-style memory responder with a zero-fill init sweep.
// Ports: clk/reset (async active-low); ddr_wr_req/ddr_rd_req/ddr_addr/ddr_wr_data request side;
//        ddr_rd_data/ddr_rd_valid read return; ddr_busy (init sweep running); req_dropped (request refused).
// Optional: define DDR_RESPONDER_STATS_EN to add saturating 16-bit wr_count/rd_count outputs.
module ddr_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1   // legal range 1..8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ddr_wr_req,
  input  logic                  ddr_rd_req,
  input  logic [ADDR_WIDTH-1:0] ddr_addr,
  input  logic [DATA_WIDTH-1:0] ddr_wr_data,
  output logic [DATA_WIDTH-1:0] ddr_rd_data,
  output logic                  ddr_rd_valid,
  output logic                  ddr_busy,
  output logic                  req_dropped
`ifdef DDR_RESPONDER_STATS_EN
  ,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_addr, sweep_addr_nxt;
  logic                  wr_acc, rd_acc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read pipeline: stage 0 captures the array word, the last stage drives the outputs.
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat [RD_LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      sweep_addr <= '0;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sweep_addr_nxt = sweep_addr;
    ddr_busy       = 1'b0;
    wr_acc         = 1'b0;
    rd_acc         = 1'b0;
    case (state)
      ST_INIT: begin
        ddr_busy       = 1'b1;
        sweep_addr_nxt = sweep_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (sweep_addr == {ADDR_WIDTH{1'b1}}) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        wr_acc = ddr_wr_req;
        rd_acc = ddr_rd_req;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Storage has no reset; the sweep is what clears it. While reset is held the
  // sweep pointer sits at 0, which only ever rewrites address 0 with zero.
  always_ff @(posedge clk) begin
    if (ddr_busy) begin
      mem[sweep_addr] <= '0;
    end else if (wr_acc) begin
      mem[ddr_addr] <= ddr_wr_data;
    end
  end

  // The array read here sees the pre-edge contents, so a same-edge write and
  // read of one address returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) begin
        pipe_dat[0] <= mem[ddr_addr];
      end
      // Data only advances behind a valid, so the last stage holds the most
      // recently returned word between pulses.
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  assign ddr_rd_valid = pipe_vld[RD_LATENCY-1];
  assign ddr_rd_data  = pipe_dat[RD_LATENCY-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_dropped <= 1'b0;
    end else begin
      req_dropped <= ddr_busy & (ddr_wr_req | ddr_rd_req);
    end
  end

`ifdef DDR_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_acc && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (rd_acc && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddr_responder.sv
`timescale 1ns/1ps
module tb_ddr_responder;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req, rd_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data1, rd_data4;
  logic          vld1, vld4, busy1, busy4, drop1, drop4;
`ifdef DDR_RESPONDER_STATS_EN
  logic [15:0]   wrc1, rdc1, wrc4, rdc4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst_n), .ddr_wr_req(wr_req), .ddr_rd_req(rd_req),
    .ddr_addr(addr), .ddr_wr_data(wr_data), .ddr_rd_data(rd_data1),
    .ddr_rd_valid(vld1), .ddr_busy(busy1), .req_dropped(drop1)
`ifdef DDR_RESPONDER_STATS_EN
    , .wr_count(wrc1), .rd_count(rdc1)
`endif
  );

  ddr_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4)) u_lat4 (
    .clk(clk), .reset(rst_n), .ddr_wr_req(wr_req), .ddr_rd_req(rd_req),
    .ddr_addr(addr), .ddr_wr_data(wr_data), .ddr_rd_data(rd_data4),
    .ddr_rd_valid(vld4), .ddr_busy(busy4), .req_dropped(drop4)
`ifdef DDR_RESPONDER_STATS_EN
    , .wr_count(wrc4), .rd_count(rdc4)
`endif
  );

  // Reference model: a word array, a count of remaining sweep cycles and, per
  // latency, a queue of (due cycle, word) read returns.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  rd_t           q1[$];
  rd_t           q4[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            sweep_left;
  int            cyc = 0;
  logic          e_vld1, e_vld4, e_busy, e_drop;
  logic [DW-1:0] e_dat1, e_dat4;

  task automatic model_flush();
    q1.delete();
    q4.delete();
    sweep_left = DEPTH;
    e_vld1 = 1'b0; e_vld4 = 1'b0;
    e_dat1 = '0;   e_dat4 = '0;
    e_busy = 1'b1; e_drop = 1'b0;
  endtask

  // Advance the model by one clock edge using the current inputs, then let the
  // DUT take that edge; outputs are sampled 1ns later.
  task automatic step();
    bit  busy_now;
    rd_t r;
    busy_now = (sweep_left > 0);
    cyc++;
    e_drop = busy_now && (wr_req || rd_req);
    if (busy_now) begin
      mem_m[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (rd_req) begin
        r.d = mem_m[addr];
        r.due = cyc;     q1.push_back(r);
        r.due = cyc + 3; q4.push_back(r);
      end
      if (wr_req) mem_m[addr] = wr_data;
    end
    e_vld1 = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      r = q1.pop_front(); e_vld1 = 1'b1; e_dat1 = r.d;
    end
    e_vld4 = 1'b0;
    if (q4.size() > 0 && q4[0].due == cyc) begin
      r = q4.pop_front(); e_vld4 = 1'b1; e_dat4 = r.d;
    end
    e_busy = (sweep_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; idle_in(); addr = '0; wr_data = '0;
    #2 rst_n = 1'b0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL reset_vld1: got %b want 0", vld1); end
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL reset_vld4: got %b want 0", vld4); end
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL reset_data1: got %h want 0", rd_data1); end
    checks++; if (rd_data4 !== 32'h0) begin errors++; $display("FAIL reset_data4: got %h want 0", rd_data4); end
    checks++; if (busy1 !== 1'b1 || busy4 !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b%b want 11", busy1, busy4); end
    checks++; if (drop1 !== 1'b0 || drop4 !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b%b want 00", drop1, drop4); end
    rst_n = 1'b1;
  endtask

  task automatic test_init_sweep();
    int n;
    bit saw_vld;
    // A write and a read during the sweep must both be refused.
    wr_req = 1'b1; rd_req = 1'b1; addr = 10'd10; wr_data = $urandom | 32'h1;
    step();
    checks++; if (drop1 !== 1'b1 || drop4 !== 1'b1) begin errors++; $display("FAIL init_drop_pulse: got %b%b want 11", drop1, drop4); end
    idle_in();
    step();
    checks++; if (drop1 !== 1'b0 || drop4 !== 1'b0) begin errors++; $display("FAIL init_drop_single: got %b%b want 00", drop1, drop4); end
    n = 2; saw_vld = 0;
    while (busy1 === 1'b1 && n < 2000) begin
      step();
      n++;
      if (vld1 === 1'b1 || vld4 === 1'b1) saw_vld = 1;
    end
    checks++; if (n != 1024) begin errors++; $display("FAIL init_busy_cycles: got %0d want 1024", n); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL init_busy4_low: got %b want 0", busy4); end
    checks++; if (saw_vld) begin errors++; $display("FAIL init_no_valid: got valid during sweep want none"); end
    rd_req = 1'b1; addr = 10'd10;
    step();
    idle_in();
    checks++; if (vld1 !== 1'b1 || rd_data1 !== 32'h0) begin errors++; $display("FAIL init_read10_lat1: got vld=%b data=%h want 1/0", vld1, rd_data1); end
    repeat (3) step();
    checks++; if (vld4 !== 1'b1 || rd_data4 !== 32'h0) begin errors++; $display("FAIL init_read10_lat4: got vld=%b data=%h want 1/0", vld4, rd_data4); end
  endtask

  task automatic test_write_read();
    wr_req = 1'b1; addr = 10'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_req = 1'b0; rd_req = 1'b1;
    step();
    idle_in();
    checks++; if (vld1 !== 1'b1 || rd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_lat1: got vld=%b data=%h want 1/deadbeef", vld1, rd_data1); end
    step();
    checks++; if (vld1 !== 1'b0 || rd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_hold: got vld=%b data=%h want 0/deadbeef", vld1, rd_data1); end
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL wr_rd_lat4_early: got %b want 0", vld4); end
    step();
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL wr_rd_lat4_early2: got %b want 0", vld4); end
    step();
    checks++; if (vld4 !== 1'b1 || rd_data4 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_lat4: got vld=%b data=%h want 1/deadbeef", vld4, rd_data4); end
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 3; a++) begin
      wr_req = 1'b1; addr = 10'(a); wr_data = 32'h11 * a;
      step();
    end
    idle_in();
    for (int k = 0; k < 7; k++) begin
      bit exp1, exp4;
      if (k < 3) begin rd_req = 1'b1; addr = 10'(k + 1); end
      else rd_req = 1'b0;
      step();
      exp1 = (k < 3);
      exp4 = (k >= 3) && (k < 6);
      checks++; if (vld1 !== exp1) begin errors++; $display("FAIL b2b_vld1 k=%0d: got %b want %b", k, vld1, exp1); end
      if (exp1) begin
        checks++; if (rd_data1 !== 32'h11 * (k + 1)) begin errors++; $display("FAIL b2b_data1 k=%0d: got %h want %h", k, rd_data1, 32'h11 * (k + 1)); end
      end
      checks++; if (vld4 !== exp4) begin errors++; $display("FAIL b2b_vld4 k=%0d: got %b want %b", k, vld4, exp4); end
      if (exp4) begin
        checks++; if (rd_data4 !== 32'h11 * (k - 2)) begin errors++; $display("FAIL b2b_data4 k=%0d: got %h want %h", k, rd_data4, 32'h11 * (k - 2)); end
      end
    end
  endtask

  task automatic test_read_before_write();
    wr_req = 1'b1; addr = 10'd7; wr_data = 32'hCAFEBABE;
    step();
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 32'h12345678;
    step();
    checks++; if (vld1 !== 1'b1 || rd_data1 !== 32'hCAFEBABE) begin errors++; $display("FAIL rbw_old: got vld=%b data=%h want 1/cafebabe", vld1, rd_data1); end
    wr_req = 1'b0;
    step();
    idle_in();
    checks++; if (vld1 !== 1'b1 || rd_data1 !== 32'h12345678) begin errors++; $display("FAIL rbw_new: got vld=%b data=%h want 1/12345678", vld1, rd_data1); end
    repeat (2) step();
    checks++; if (vld4 !== 1'b1 || rd_data4 !== 32'hCAFEBABE) begin errors++; $display("FAIL rbw_old_lat4: got vld=%b data=%h want 1/cafebabe", vld4, rd_data4); end
    step();
    checks++; if (vld4 !== 1'b1 || rd_data4 !== 32'h12345678) begin errors++; $display("FAIL rbw_new_lat4: got vld=%b data=%h want 1/12345678", vld4, rd_data4); end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_req  = 1'($urandom);
      rd_req  = 1'($urandom);
      addr    = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      wr_data = $urandom;
      step();
      checks++; if (vld1 !== e_vld1 || rd_data1 !== e_dat1) begin errors++; $display("FAIL rand_lat1 i=%0d: got vld=%b data=%h want %b/%h", i, vld1, rd_data1, e_vld1, e_dat1); end
      checks++; if (vld4 !== e_vld4 || rd_data4 !== e_dat4) begin errors++; $display("FAIL rand_lat4 i=%0d: got vld=%b data=%h want %b/%h", i, vld4, rd_data4, e_vld4, e_dat4); end
      checks++; if (busy1 !== e_busy || drop1 !== e_drop) begin errors++; $display("FAIL rand_ctl i=%0d: got busy=%b drop=%b want %b/%b", i, busy1, drop1, e_busy, e_drop); end
    end
    idle_in();
    repeat (4) step();
  endtask

  task automatic test_reset_in_flight();
    int  n;
    bit  saw_vld;
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1; addr = 10'($urandom_range(0, 15));
      step();
    end
    idle_in();
    #2 rst_n = 1'b0;
    model_flush();
    saw_vld = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (vld4 === 1'b1 || vld1 === 1'b1) saw_vld = 1;
    end
    checks++; if (saw_vld) begin errors++; $display("FAIL flight_valid_in_reset: got valid want none"); end
    rst_n = 1'b1;
    rd_req = 1'b1; addr = 10'd3;
    step();
    idle_in();
    checks++; if (drop1 !== 1'b1 || drop4 !== 1'b1) begin errors++; $display("FAIL flight_drop_after_reset: got %b%b want 11", drop1, drop4); end
    n = 1; saw_vld = 0;
    while (busy4 === 1'b1 && n < 2000) begin
      step();
      n++;
      if (vld1 === 1'b1 || vld4 === 1'b1) saw_vld = 1;
    end
    checks++; if (n != 1024) begin errors++; $display("FAIL flight_sweep_restart: got %0d busy cycles want 1024", n); end
    checks++; if (saw_vld) begin errors++; $display("FAIL flight_no_valid: got valid after reset want none"); end
  endtask

`ifdef DDR_RESPONDER_STATS_EN
  task automatic test_stats();
    int n;
    #2 rst_n = 1'b0;
    model_flush();
    @(posedge clk); #1;
    checks++; if (wrc1 !== 16'd0 || rdc1 !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d want 0/0", wrc1, rdc1); end
    rst_n = 1'b1;
    rd_req = 1'b1; addr = 10'd2;
    step();
    idle_in();
    n = 1;
    while (busy1 === 1'b1 && n < 2000) begin step(); n++; end
    checks++; if (n != 1024) begin errors++; $display("FAIL stats_sweep: got %0d want 1024", n); end
    for (int k = 0; k < 2; k++) begin wr_req = 1'b1; addr = 10'(k); wr_data = $urandom; step(); end
    wr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin rd_req = 1'b1; addr = 10'(k); step(); end
    idle_in();
    step();
    checks++; if (wrc1 !== 16'd2 || rdc1 !== 16'd3) begin errors++; $display("FAIL stats_lat1: got %0d/%0d want 2/3", wrc1, rdc1); end
    checks++; if (wrc4 !== 16'd2 || rdc4 !== 16'd3) begin errors++; $display("FAIL stats_lat4: got %0d/%0d want 2/3", wrc4, rdc4); end
  endtask
`endif

  initial begin
    test_reset();
    test_init_sweep();
    test_write_read();
    test_back_to_back();
    test_read_before_write();
    test_random();
    test_reset_in_flight();
`ifdef DDR_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
